// File: rtl/fmap_reader_pkg.sv
// rtl/fmap_reader_pkg.sv - shared widths and FSM encoding for the feature-map reader
package fmap_reader_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int WORD_W_DEF = 64;
   localparam int BYTE_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/fmap_reader_word_fifo2.sv
// rtl/fmap_reader_word_fifo2.sv - two-entry word buffer between BRAM returns and the byte unpacker
module word_fifo2
   import fmap_reader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] din,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [WORD_W-1:0] head
);
   logic [WORD_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        cnt_q;
   logic              do_push;
   logic              do_pop;

   // a push is accepted when there is room or the head leaves in the same cycle
   always_comb begin
      full    = (cnt_q == 2'd2);
      empty   = (cnt_q == 2'd0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      head    = mem_q[rd_ptr_q];
   end

   // storage, pointers and occupancy; push+pop together leaves occupancy unchanged
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/fmap_reader.sv
// rtl/fmap_reader.sv - streams a BRAM feature-map region out as bytes with ready/valid flow control
module fmap_reader
   import fmap_reader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_cnt,
   output logic              busy,
   output logic              done,
   output logic              en_BRAM32k,
   output logic [ADDR_W-1:0] addr_BRAM32k,
   input  logic [WORD_W-1:0] dout_BRAM32k,
   output logic [7:0]        out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);
   localparam int                BYTES    = WORD_W / BYTE_W;
   localparam int                IDX_W    = $clog2(BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);

   state_t            state_q;
   state_t            state_d;
   logic              en_q;
   logic              ret_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   issue_left_q;
   logic [ADDR_W:0]   pop_left_q;
   logic [IDX_W-1:0]  idx_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WORD_W-1:0] fifo_head;
   logic              hs;
   logic              word_end;
   logic              final_hs;
   logic              issue_ok;
   logic [2:0]        used;

   // ret_q marks the cycle a read's data is on dout_BRAM32k; reset clears it so stale returns are dropped
   word_fifo2 #(
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ret_q),
      .din   (dout_BRAM32k),
      .pop   (word_end),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign en_BRAM32k   = en_q;
   assign addr_BRAM32k = addr_q;

   // handshake decode and credit check: reads in flight plus buffered words never exceed two
   always_comb begin
      hs       = out_valid && out_ready;
      word_end = hs && (idx_q == LAST_IDX);
      final_hs = word_end && (pop_left_q == (ADDR_W+1)'(1));
      used     = 3'(en_q) + 3'(ret_q)
               + (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1))
               - 3'(word_end);
      issue_ok = (state_q == RUN) && (issue_left_q != '0) && (used <= 3'd1);
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state: an empty region goes straight to DONE; a running region ends on its last byte
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (word_cnt == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (final_hs) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state and the head of the word buffer
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      out_valid = (state_q == RUN) && !fifo_empty;
      out_byte  = out_valid ? fifo_head[idx_q*BYTE_W +: BYTE_W] : 8'd0;
      out_last  = out_valid && (idx_q == LAST_IDX) && (pop_left_q == (ADDR_W+1)'(1));
   end

   // read issue, region counters and byte index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q         <= 1'b0;
         ret_q        <= 1'b0;
         addr_q       <= '0;
         rd_ptr_q     <= '0;
         issue_left_q <= '0;
         pop_left_q   <= '0;
         idx_q        <= '0;
      end else begin
         ret_q <= en_q;
         en_q  <= issue_ok;
         if ((state_q == IDLE) && start) begin
            rd_ptr_q     <= base_addr;
            issue_left_q <= word_cnt;
            pop_left_q   <= word_cnt;
            idx_q        <= '0;
         end
         if (issue_ok) begin
            addr_q       <= rd_ptr_q;
            rd_ptr_q     <= rd_ptr_q + 1'b1;
            issue_left_q <= issue_left_q - 1'b1;
         end
         if (hs) begin
            idx_q <= word_end ? '0 : idx_q + 1'b1;
         end
         if (word_end) begin
            pop_left_q <= pop_left_q - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fmap_reader.sv
// tb/tb_fmap_reader.sv - randomized self-checking bench for fmap_reader
module tb_fmap_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [12:0] word_cnt = '0;
   logic        busy;
   logic        done;
   logic        en_BRAM32k;
   logic [11:0] addr_BRAM32k;
   logic [63:0] dout_BRAM32k = '0;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;

   logic [63:0] mem [4096];
   int          checks = 0;
   int          failures = 0;

   fmap_reader #(
      .ADDR_W (12),
      .WORD_W (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .word_cnt     (word_cnt),
      .busy         (busy),
      .done         (done),
      .en_BRAM32k   (en_BRAM32k),
      .addr_BRAM32k (addr_BRAM32k),
      .dout_BRAM32k (dout_BRAM32k),
      .out_byte     (out_byte),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   // synchronous-read BRAM: data appears one cycle after the enable
   always @(posedge clk) begin
      if (en_BRAM32k) dout_BRAM32k <= mem[addr_BRAM32k];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk(tag, 64'({busy, done, en_BRAM32k, addr_BRAM32k, out_byte, out_valid, out_last}), 64'd0);
   endtask

   // mode 0: ready always high, 1: toggled every cycle, 2: random
   task automatic run_region(input logic [11:0] base, input int cnt, input int mode,
                             input int abort_at, input bit restart);
      byte unsigned exp_q[$];
      logic [63:0]  w;
      logic [7:0]   prev_byte;
      int           nb, got, reads, pops, first_valid, limit, cyc;
      bit           prev_stall, done_seen;
      nb = cnt * 8;
      for (int i = 0; i < nb; i++) begin
         w = mem[12'(base + i / 8)];
         exp_q.push_back(w[(i % 8) * 8 +: 8]);
      end
      got = 0; reads = 0; first_valid = -1; prev_stall = 0; done_seen = 0; prev_byte = '0;
      limit = 60 + nb * 6;

      @(posedge clk); #1;
      start = 1'b1; base_addr = base; word_cnt = 13'(cnt);
      @(posedge clk); #1;
      start = 1'b0; base_addr = ~base; word_cnt = 13'h1FFF;

      for (cyc = 0; cyc < limit; cyc++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (restart && cyc == 6) begin
            start = 1'b1; base_addr = base + 12'h155; word_cnt = 13'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (cyc == 0) chk("busy_after_start", 64'(busy), 64'd1);
         pops = got / 8;
         if (en_BRAM32k) begin
            chk("rd_excess", 64'(reads < cnt), 64'd1);
            chk("rd_addr", 64'(addr_BRAM32k), 64'(12'(base + reads)));
            reads++;
         end
         chk("credit", 64'((reads - pops) <= 2), 64'd1);
         if (out_valid && first_valid < 0) begin
            first_valid = cyc;
            chk("latency", 64'(cyc), 64'd3);
         end
         if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_byte", 64'(out_byte), 64'(prev_byte));
         end
         if (mode == 0 && first_valid >= 0 && got < nb)
            chk("no_bubble", 64'(out_valid), 64'd1);
         if (out_valid) begin
            chk("last", 64'(out_last), 64'(got == nb - 1));
            if (out_ready) begin
               if (got < nb) chk("byte", 64'(out_byte), 64'(exp_q[got]));
               else          chk("extra_byte", 64'(got + 1), 64'(nb));
               got++;
            end
         end else begin
            chk("last_idle", 64'(out_last), 64'd0);
         end
         prev_stall = out_valid && !out_ready;
         prev_byte  = out_byte;

         if (abort_at >= 0 && got >= abort_at) begin
            rst = 1'b0;
            #1;
            chk_outputs_zero("reset_midrun");
            repeat (2) @(negedge clk);
            rst = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("stale_discard", 64'({out_valid, en_BRAM32k, busy}), 64'd0);
            end
            start = 1'b0;
            return;
         end

         if (done) begin
            done_seen = 1;
            chk("done_bytes", 64'(got), 64'(nb));
            chk("done_busy", 64'(busy), 64'd1);
            if (cnt == 0)       chk("done_lat_empty", 64'(cyc <= 1), 64'd1);
            else if (mode == 0) chk("done_lat", 64'(cyc), 64'(3 + nb));
            @(negedge clk);
            chk("done_pulse", 64'({done, busy}), 64'd0);
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (!done_seen) chk("timeout", 64'd0, 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
      mem[12'h010] = 64'h8877665544332211;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset_state");
      rst = 1'b1;

      run_region(12'h010, 1, 0, -1, 1'b0);
      run_region(12'h123, 0, 0, -1, 1'b0);
      run_region(12'hFFE, 3, 0, -1, 1'b0);
      run_region(12'h200, 4, 1, -1, 1'b0);
      run_region(12'h300, 8, 0, 13, 1'b0);
      run_region(12'h010, 1, 0, -1, 1'b0);
      run_region(12'h400, 3, 0, -1, 1'b1);
      run_region(12'h7F0, 3, 2, -1, 1'b1);
      for (int r = 0; r < 10; r++)
         run_region(12'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), -1, 1'b0);
      run_region(12'hFF0, 40, 0, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
